// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle control unit for the MIPS datapath.
// Walks each instruction through IF/ID/EX/MEM/WB and decodes the datapath
// enables and selector codes from the current state and the IR opcode/funct.
module mc_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [5:0]  opcode,
    input  logic [5:0]  funct,
    input  logic        zero,
    output logic        pc_we,
    output logic        ir_we,
    output logic        reg_we,
    output logic        mem_we,
    output logic [1:0]  regdst_sel,
    output logic [2:0]  wd_sel,
    output logic [1:0]  npc_sel,
    output logic        alub_sel,
    output logic        ext_op,
    output logic [1:0]  alu_op,
    output logic [2:0]  state,
    output logic        instr_done,
    output logic [31:0] retired
);

    typedef enum logic [2:0] {
        S_IF  = 3'b000,
        S_ID  = 3'b001,
        S_EX  = 3'b010,
        S_MEM = 3'b011,
        S_WB  = 3'b100
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] retired_q, retired_d;

    // Instruction decode from the IR fields.
    logic is_r, is_addu, is_subu, is_jr, is_ori, is_lui, is_lw, is_sw, is_beq, is_j, is_jal;

    assign is_r    = (opcode == 6'b000000);
    assign is_addu = is_r && (funct == 6'b100001);
    assign is_subu = is_r && (funct == 6'b100011);
    assign is_jr   = is_r && (funct == 6'b001000);
    assign is_ori  = (opcode == 6'b001101);
    assign is_lui  = (opcode == 6'b001111);
    assign is_lw   = (opcode == 6'b100011);
    assign is_sw   = (opcode == 6'b101011);
    assign is_beq  = (opcode == 6'b000100);
    assign is_j    = (opcode == 6'b000010);
    assign is_jal  = (opcode == 6'b000011);

    // Next-state sequencing; anything unrecognised falls back to IF.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        state_d = S_IF;
        case (state_q)
            S_IF:    state_d = S_ID;
            S_ID: begin
                if (is_addu || is_subu || is_ori || is_lw || is_sw || is_beq) state_d = S_EX;
                else if (is_lui)                                              state_d = S_WB;
                else                                                          state_d = S_IF;
            end
            S_EX: begin
                if (is_lw || is_sw)                     state_d = S_MEM;
                else if (is_addu || is_subu || is_ori)  state_d = S_WB;
                else                                    state_d = S_IF;
            end
            S_MEM:   state_d = is_lw ? S_WB : S_IF;
            S_WB:    state_d = S_IF;
            default: state_d = S_IF;
        endcase
    end

    // Enable/select decode; everything is held at 0 while reset is asserted so
    // an asynchronous reset kills write enables without waiting for a clock.
    always_comb begin
        pc_we      = 1'b0;
        ir_we      = 1'b0;
        reg_we     = 1'b0;
        mem_we     = 1'b0;
        regdst_sel = 2'b00;
        wd_sel     = 3'b000;
        npc_sel    = 2'b00;
        alub_sel   = 1'b0;
        ext_op     = 1'b0;
        alu_op     = 2'b00;
        instr_done = 1'b0;
        if (rst_n) begin
            case (state_q)
                S_IF: begin
                    pc_we = 1'b1;
                    ir_we = 1'b1;
                end
                S_ID: begin
                    if (is_j || is_jal) begin
                        pc_we   = 1'b1;
                        npc_sel = 2'b10;
                    end
                    if (is_jal) begin
                        reg_we     = 1'b1;
                        regdst_sel = 2'b10;
                        wd_sel     = 3'b010;
                    end
                    if (is_jr) begin
                        pc_we   = 1'b1;
                        npc_sel = 2'b11;
                    end
                end
                S_EX: begin
                    if (is_subu) alu_op = 2'b01;
                    if (is_ori) begin
                        alub_sel = 1'b1;
                        alu_op   = 2'b10;
                    end
                    if (is_lw || is_sw) begin
                        alub_sel = 1'b1;
                        ext_op   = 1'b1;
                    end
                    if (is_beq) begin
                        alu_op  = 2'b01;
                        npc_sel = 2'b01;
                        ext_op  = 1'b1;
                        pc_we   = zero;
                    end
                end
                S_MEM: begin
                    if (is_sw) mem_we = 1'b1;
                    // Load keeps the address path steady for the memory read.
                    if (is_lw) begin
                        alub_sel = 1'b1;
                        ext_op   = 1'b1;
                    end
                end
                S_WB: begin
                    reg_we = 1'b1;
                    if (is_r)   regdst_sel = 2'b01;
                    if (is_lw)  wd_sel     = 3'b001;
                    if (is_lui) wd_sel     = 3'b011;
                end
                default: ;
            endcase
            // The last state of any sequence is the one that returns to IF.
            instr_done = (state_q != S_IF) && (state_d == S_IF);
        end
    end

    assign retired_d = instr_done ? retired_q + 32'd1 : retired_q;

    // State register and retired-instruction counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IF;
            retired_q <= 32'd0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            state_q   <= state_d;
            retired_q <= retired_d;
        end
    end

    assign state   = state_q;
    assign retired = retired_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: table-driven check of mc_ctrl, one record per clock cycle,
// plus a hand-written mid-instruction reset sequence.
module tb_mc_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic        zero;
    logic        pc_we, ir_we, reg_we, mem_we;
    logic [1:0]  regdst_sel;
    logic [2:0]  wd_sel;
    logic [1:0]  npc_sel;
    logic        alub_sel, ext_op;
    logic [1:0]  alu_op;
    logic [2:0]  state;
    logic        instr_done;
    logic [31:0] retired;

    int checks   = 0;
    int failures = 0;

    mc_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .opcode     (opcode),
        .funct      (funct),
        .zero       (zero),
        .pc_we      (pc_we),
        .ir_we      (ir_we),
        .reg_we     (reg_we),
        .mem_we     (mem_we),
        .regdst_sel (regdst_sel),
        .wd_sel     (wd_sel),
        .npc_sel    (npc_sel),
        .alub_sel   (alub_sel),
        .ext_op     (ext_op),
        .alu_op     (alu_op),
        .state      (state),
        .instr_done (instr_done),
        .retired    (retired)
    );

    always #5 clk = ~clk;

    // Packed output view: {state,pc,ir,reg,mem,regdst,wd,npc,alub,ext,alu,done}
    typedef struct {
        string       name;
        logic [5:0]  op;
        logic [5:0]  fn;
        logic        z;
        logic [18:0] exp;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [18:0] outs();
        return {state, pc_we, ir_we, reg_we, mem_we, regdst_sel, wd_sel,
                npc_sel, alub_sel, ext_op, alu_op, instr_done};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic add(input string name, input logic [5:0] op, input logic [5:0] fn, input logic z,
                       input logic [2:0] st, input logic pc, input logic ir, input logic rw,
                       input logic mw, input logic [1:0] rd, input logic [2:0] wd,
                       input logic [1:0] npc, input logic ab, input logic ex,
                       input logic [1:0] alu, input logic dn);
        vec_t v;
        v.name = name;
        v.op   = op;
        v.fn   = fn;
        v.z    = z;
        v.exp  = {st, pc, ir, rw, mw, rd, wd, npc, ab, ex, alu, dn};
        vecs.push_back(v);
    endtask

    // Common IF and plain-ID rows.
    task automatic add_if(input string name, input logic [5:0] op, input logic [5:0] fn, input logic z);
        add({name, "_if"}, op, fn, z, 3'd0, 1, 1, 0, 0, 2'b00, 3'b000, 2'b00, 0, 0, 2'b00, 0);
    endtask

    task automatic add_id(input string name, input logic [5:0] op, input logic [5:0] fn, input logic z);
        add({name, "_id"}, op, fn, z, 3'd1, 0, 0, 0, 0, 2'b00, 3'b000, 2'b00, 0, 0, 2'b00, 0);
    endtask

    localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011,
                           OP_ORI = 6'b001101, OP_LUI = 6'b001111, OP_BEQ = 6'b000100,
                           OP_J = 6'b000010, OP_JAL = 6'b000011, OP_BAD = 6'b111111;
    localparam logic [5:0] FN_ADDU = 6'b100001, FN_SUBU = 6'b100011, FN_JR = 6'b001000,
                           FN_SLL = 6'b000000;

    int exp_ret;

    initial begin
        // ---------------- vector table ----------------
        //                                    st   pc ir rw mw rd     wd      npc    ab ex alu    dn
        add_if("lw", OP_LW, 0, 0);
        add_id("lw", OP_LW, 0, 0);
        add("lw_ex",  OP_LW, 0, 0,          3'd2, 0, 0, 0, 0, 2'b00, 3'b000, 2'b00, 1, 1, 2'b00, 0);
        add("lw_mem", OP_LW, 0, 0,          3'd3, 0, 0, 0, 0, 2'b00, 3'b000, 2'b00, 1, 1, 2'b00, 0);
        add("lw_wb",  OP_LW, 0, 0,          3'd4, 0, 0, 1, 0, 2'b00, 3'b001, 2'b00, 0, 0, 2'b00, 1);
        add_if("addu", OP_R, FN_ADDU, 0);
        add_id("addu", OP_R, FN_ADDU, 0);
        add("addu_ex", OP_R, FN_ADDU, 0,    3'd2, 0, 0, 0, 0, 2'b00, 3'b000, 2'b00, 0, 0, 2'b00, 0);
        add("addu_wb", OP_R, FN_ADDU, 0,    3'd4, 0, 0, 1, 0, 2'b01, 3'b000, 2'b00, 0, 0, 2'b00, 1);
        add_if("subu", OP_R, FN_SUBU, 0);
        add_id("subu", OP_R, FN_SUBU, 0);
        add("subu_ex", OP_R, FN_SUBU, 0,    3'd2, 0, 0, 0, 0, 2'b00, 3'b000, 2'b00, 0, 0, 2'b01, 0);
        add("subu_wb", OP_R, FN_SUBU, 0,    3'd4, 0, 0, 1, 0, 2'b01, 3'b000, 2'b00, 0, 0, 2'b00, 1);
        add_if("ori", OP_ORI, 0, 0);
        add_id("ori", OP_ORI, 0, 0);
        add("ori_ex", OP_ORI, 0, 0,         3'd2, 0, 0, 0, 0, 2'b00, 3'b000, 2'b00, 1, 0, 2'b10, 0);
        add("ori_wb", OP_ORI, 0, 0,         3'd4, 0, 0, 1, 0, 2'b00, 3'b000, 2'b00, 0, 0, 2'b00, 1);
        add_if("lui", OP_LUI, 0, 0);
        add_id("lui", OP_LUI, 0, 0);
        add("lui_wb", OP_LUI, 0, 0,         3'd4, 0, 0, 1, 0, 2'b00, 3'b011, 2'b00, 0, 0, 2'b00, 1);
        add_if("sw", OP_SW, 0, 0);
        add_id("sw", OP_SW, 0, 0);
        add("sw_ex",  OP_SW, 0, 0,          3'd2, 0, 0, 0, 0, 2'b00, 3'b000, 2'b00, 1, 1, 2'b00, 0);
        add("sw_mem", OP_SW, 0, 0,          3'd3, 0, 0, 0, 1, 2'b00, 3'b000, 2'b00, 0, 0, 2'b00, 1);
        add_if("beq_t", OP_BEQ, 0, 1);
        add_id("beq_t", OP_BEQ, 0, 1);
        add("beq_t_ex", OP_BEQ, 0, 1,       3'd2, 1, 0, 0, 0, 2'b00, 3'b000, 2'b01, 0, 1, 2'b01, 1);
        add_if("beq_n", OP_BEQ, 0, 1);
        add_id("beq_n", OP_BEQ, 0, 1);
        add("beq_n_ex", OP_BEQ, 0, 0,       3'd2, 0, 0, 0, 0, 2'b00, 3'b000, 2'b01, 0, 1, 2'b01, 1);
        add_if("j", OP_J, 0, 0);
        add("j_id",   OP_J, 0, 0,           3'd1, 1, 0, 0, 0, 2'b00, 3'b000, 2'b10, 0, 0, 2'b00, 1);
        add_if("jal", OP_JAL, 0, 0);
        add("jal_id", OP_JAL, 0, 0,         3'd1, 1, 0, 1, 0, 2'b10, 3'b010, 2'b10, 0, 0, 2'b00, 1);
        add_if("jr", OP_R, FN_JR, 0);
        add("jr_id",  OP_R, FN_JR, 0,       3'd1, 1, 0, 0, 0, 2'b00, 3'b000, 2'b11, 0, 0, 2'b00, 1);
        add_if("bad", OP_BAD, 0, 0);
        add("bad_id", OP_BAD, 0, 0,         3'd1, 0, 0, 0, 0, 2'b00, 3'b000, 2'b00, 0, 0, 2'b00, 1);
        add_if("sll", OP_R, FN_SLL, 0);
        add("sll_id", OP_R, FN_SLL, 0,      3'd1, 0, 0, 0, 0, 2'b00, 3'b000, 2'b00, 0, 0, 2'b00, 1);

        // ---------------- reset ----------------
        rst_n  = 1'b0;
        opcode = OP_LW;
        funct  = 6'd0;
        zero   = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("reset_outputs", {13'd0, outs()}, 32'd0);
            check("reset_retired", retired, 32'd0);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;

        // ---------------- table loop ----------------
        exp_ret = 0;
        for (int i = 0; i < vecs.size(); i++) begin
            opcode = vecs[i].op;
            funct  = vecs[i].fn;
            zero   = vecs[i].z;
            @(negedge clk);
            check(vecs[i].name, {13'd0, outs()}, {13'd0, vecs[i].exp});
            check({vecs[i].name, "_retired"}, retired, exp_ret);
            if (vecs[i].exp[0]) exp_ret++;
            @(posedge clk);
            #1;
        end

        // ---------------- reset during sw MEM ----------------
        opcode = OP_SW;
        funct  = 6'd0;
        zero   = 1'b0;
        check("sw2_if_state", {29'd0, state}, 32'd0);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        #1;
        check("sw2_mem_state", {29'd0, state}, 32'd3);
        check("sw2_mem_we", {31'd0, mem_we}, 32'd1);
        check("sw2_retired_before", retired, exp_ret);
        #1 rst_n = 1'b0;
        #1;
        check("rst_mid_mem_we", {31'd0, mem_we}, 32'd0);
        check("rst_mid_state", {29'd0, state}, 32'd0);
        check("rst_mid_outputs", {13'd0, outs()}, 32'd0);
        check("rst_mid_retired", retired, 32'd0);
        @(posedge clk);
        #1;
        check("rst_hold_outputs", {13'd0, outs()}, 32'd0);
        rst_n = 1'b1;
        #1;
        check("release_pc_ir_we", {30'd0, pc_we, ir_we}, 32'd3);
        check("release_state", {29'd0, state}, 32'd0);
        check("release_retired", retired, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mc_ctrl.md
# mc_ctrl

Multi-cycle control unit for the MIPS datapath. It sequences each instruction through IF/ID/EX/MEM/WB states. It drives the select codes consumed by the datapath selectors: register-destination 3-way 5-bit, write-data 5-way 32-bit, next-PC 4-way 32-bit and ALU-B 2-way 32-bit. It also drives the PC, IR, register-file and data-memory write enables. It sits between the instruction register (opcode/funct source) and every selector and state element in the datapath.

## Interface
- No parameters.
- clk  in  1  datapath clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- opcode  in  6  IR[31:26]; must be stable from the cycle after IF.
- funct  in  6  IR[5:0].
- zero  in  1  ALU equality flag, valid in EX.
- pc_we  out  1  PC write enable.
- ir_we  out  1  IR write enable.
- reg_we  out  1  register-file write enable.
- mem_we  out  1  data-memory write enable.
- regdst_sel  out  2  destination register: 00 rt, 01 rd, 10 $31.
- wd_sel  out  3  write data: 000 ALU, 001 memory, 010 PC+4, 011 {imm,16'b0}; 100 is reserved and never driven.
- npc_sel  out  2  next PC: 00 PC+4, 01 branch target, 10 jump target, 11 rs.
- alub_sel  out  1  ALU B input: 0 rt, 1 extended immediate.
- ext_op  out  1  immediate extension: 0 zero-extend, 1 sign-extend.
- alu_op  out  2  ALU operation: 00 add, 01 sub, 10 or.
- state  out  3  current state: 000 IF, 001 ID, 010 EX, 011 MEM, 100 WB.
- instr_done  out  1  one-cycle pulse in the final cycle of each instruction.
- retired  out  32  count of completed instructions.

## Operation
- Supported instructions and their state sequences:
  - addu (op 000000, funct 100001) and subu (funct 100011): IF ID EX WB.
  - jr (funct 001000): IF ID.
  - ori (001101): IF ID EX WB.
  - lui (001111): IF ID WB.
  - lw (100011): IF ID EX MEM WB.
  - sw (101011): IF ID EX MEM.
  - beq (000100): IF ID EX.
  - j (000010) and jal (000011): IF ID.
- Any other opcode, or an R-type funct not listed, executes as a nop: IF ID, then back to IF.
- IF state: pc_we=1, ir_we=1, npc_sel=00.
- ID state:
  - j: pc_we=1, npc_sel=10.
  - jal: pc_we=1, npc_sel=10, reg_we=1, regdst_sel=10, wd_sel=010.
  - jr: pc_we=1, npc_sel=11.
- EX state:
  - R-type: alub_sel=0, alu_op=00 for addu, 01 for subu.
  - ori: alub_sel=1, ext_op=0, alu_op=10.
  - lw/sw: alub_sel=1, ext_op=1, alu_op=00.
  - beq: alu_op=01, npc_sel=01, ext_op=1, pc_we=zero.
- MEM state: sw drives mem_we=1. lw holds its EX selects for the memory read.
- WB state, always reg_we=1:
  - R-type: regdst_sel=01, wd_sel=000.
  - ori: regdst_sel=00, wd_sel=000.
  - lw: regdst_sel=00, wd_sel=001.
  - lui: regdst_sel=00, wd_sel=011.
- All outputs not listed for a state are 0.
- Enables and selects are combinational decodes of the state register and opcode/funct; the only inputs are opcode, funct and zero.
- instr_done=1 in the last state of each sequence, including the nop ID.
- retired increments by 1 on every clock edge where instr_done=1, and wraps 0xFFFFFFFF→0.

## Timing
- Reset:
  - state=IF, retired=0.
  - While rst_n=0, pc_we, ir_we, reg_we, mem_we and instr_done are forced 0; all selects are 0.
  - Reset asserted mid-instruction aborts it immediately; no write enable is asserted after the asynchronous assertion.
- On deassertion, the first rising edge is an IF cycle that fetches.
- Latency in cycles, counted from IF to the next IF:
  - lw 5.
  - R-type, ori and sw 4.
  - lui and beq 3.
  - j, jal, jr and nop 2.
- beq: zero is sampled only in EX. Taken or not taken, the next state is IF.
- One transition per clock edge; there are no wait states and no stalls.

## Test plan
- Reset: hold rst_n=0 for 3 cycles, then release. Required: state=000 and all enables 0 during reset; pc_we=1 and ir_we=1 in the first cycle after release; retired=0.
- lw (opcode 100011): run one instruction.
  - Required: states IF,ID,EX,MEM,WB.
  - Required in WB: reg_we=1, wd_sel=001, regdst_sel=00; instr_done pulses only in WB.
  - Required at the end: retired=1.
- beq (opcode 000100), twice:
  - With zero=1 in EX: required pc_we=1 and npc_sel=01 in EX.
  - With zero=0: required pc_we=0.
  - Both take 3 cycles.
- jal (opcode 000011): required in ID: pc_we=1, npc_sel=10, reg_we=1, regdst_sel=10, wd_sel=010; the next state is IF.
- Illegal opcode 111111: required IF, ID, IF with no reg_we or mem_we asserted; retired increments by 1.
- Reset during the sw MEM cycle: assert rst_n=0 mid-cycle. Required: mem_we drops immediately, state=IF, retired=0.
